// File: rtl/video_dram_arb_if.sv
// ---------------------------------------------------------------------------
// video_dram_arb_if
//
// Bundles every client-side and DRAM-side signal of the video DRAM arbiter.
//
//   slave  modport : seen by the arbiter (requests in, grants/strobes out,
//                    DRAM command out, DRAM read data in)
//   master modport : seen by the clients / DRAM model (mirror image)
//
// Signal groups:
//   slot timing  : c3
//   video burst  : video_go, video_addr[20:0], video_bw[4:0],
//                  video_pre_next, video_next, video_strobe
//   tile-map     : tm_req, tm_addr[20:0], tm_next
//   renderer     : ts_req, ts_addr[20:0], ts_pre_next, ts_next
//   cpu          : cpu_req, cpu_rnw, cpu_addr[20:0], cpu_wdata[15:0], cpu_ack
//   dram command : mem_req, mem_rnw, mem_addr[20:0], mem_wdata[15:0],
//                  mem_rdata[15:0]
//   read data    : dram_rdata[15:0] (registered, broadcast to all clients)
// ---------------------------------------------------------------------------
interface video_dram_arb_if;
    logic        c3;

    logic        video_go;
    logic [20:0] video_addr;
    logic [4:0]  video_bw;
    logic        video_pre_next;
    logic        video_next;
    logic        video_strobe;

    logic        tm_req;
    logic [20:0] tm_addr;
    logic        tm_next;

    logic        ts_req;
    logic [20:0] ts_addr;
    logic        ts_pre_next;
    logic        ts_next;

    logic        cpu_req;
    logic        cpu_rnw;
    logic [20:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;

    logic        mem_req;
    logic        mem_rnw;
    logic [20:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] dram_rdata;

    modport slave (
        input  c3,
        input  video_go, video_addr, video_bw,
        output video_pre_next, video_next, video_strobe,
        input  tm_req, tm_addr,
        output tm_next,
        input  ts_req, ts_addr,
        output ts_pre_next, ts_next,
        input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        output cpu_ack,
        output mem_req, mem_rnw, mem_addr, mem_wdata,
        input  mem_rdata,
        output dram_rdata
    );

    modport master (
        output c3,
        output video_go, video_addr, video_bw,
        input  video_pre_next, video_next, video_strobe,
        output tm_req, tm_addr,
        input  tm_next,
        output ts_req, ts_addr,
        input  ts_pre_next, ts_next,
        output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        input  cpu_ack,
        input  mem_req, mem_rnw, mem_addr, mem_wdata,
        output mem_rdata,
        input  dram_rdata
    );
endinterface

// File: rtl/video_dram_arb.sv
// ---------------------------------------------------------------------------
// video_dram_arb
//
// Slot-based DRAM arbiter for the video subsystem. At every slot start (the
// clk after c3) one client is chosen by fixed priority
//   video burst (vcnt != 0) > tile-map > renderer > cpu
// and a single-cycle DRAM command is issued. An owner tag follows the
// command through an RD_LAT-deep pipeline; when it leaves, the read data is
// registered into dram_rdata and the owner's data strobe fires together
// with it (grant-to-strobe = RD_LAT + 1 clk).
//
// Parameters:
//   RD_LAT : clk cycles from mem_req to valid mem_rdata, legal 1..3, so a
//            transaction always retires before the next slot's grant.
//
// Ports:
//   clk    : system clock
//   res_n  : asynchronous active-low reset
//   bus    : video_dram_arb_if.slave (client requests/strobes, DRAM command)
//
// Configuration macro:
//   VIDEO_DRAM_ARB_CPU_EN : when defined, the CPU port takes part at lowest
//                           priority (reads and writes). When undefined, CPU
//                           inputs are ignored, cpu_ack = 0, mem_rnw = 1 and
//                           mem_wdata = 0.
// ---------------------------------------------------------------------------
module video_dram_arb #(
    parameter int RD_LAT = 2
) (
    input  logic            clk,
    input  logic            res_n,
    video_dram_arb_if.slave bus
);

    typedef enum logic [1:0] {
        OWN_VID = 2'd0,
        OWN_TM  = 2'd1,
        OWN_TS  = 2'd2,
        OWN_CPU = 2'd3
    } owner_e;

    typedef struct packed {
        logic   vld;
        logic   wr;
        owner_e own;
    } tag_t;

    logic [3:0]             r_vcnt;
    logic                   r_mem_req;
    logic [20:0]            r_mem_addr;
    logic                   r_video_pre_next;
    logic                   r_video_next;
    logic                   r_video_strobe;
    logic                   r_tm_next;
    logic                   r_ts_pre_next;
    logic                   r_ts_next;
    logic [15:0]            r_dram_rdata;
    tag_t                   r_cmd;      // tag of the command on the DRAM bus
    tag_t [RD_LAT-1:0]      r_tags;     // in-flight tags while DRAM reads

    logic                   w_win_vld;
    logic                   w_win_wr;
    owner_e                 w_win_own;
    logic [20:0]            w_win_addr;
    logic                   w_grant;
    tag_t                   w_exit;

    // Winner selection. Only the winner's address/direction is looked at.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a variable unassigned and no latch is inferred.
        w_win_vld  = 1'b1;
        w_win_wr   = 1'b0;
        w_win_own  = OWN_VID;
        w_win_addr = bus.video_addr;
        if (r_vcnt == 4'd0) begin
            if (bus.tm_req) begin
                w_win_own  = OWN_TM;
                w_win_addr = bus.tm_addr;
            end else if (bus.ts_req) begin
                w_win_own  = OWN_TS;
                w_win_addr = bus.ts_addr;
            end
`ifdef VIDEO_DRAM_ARB_CPU_EN
            else if (bus.cpu_req) begin
                w_win_own  = OWN_CPU;
                w_win_addr = bus.cpu_addr;
                w_win_wr   = ~bus.cpu_rnw;
            end
`endif
            else begin
                w_win_vld = 1'b0;
            end
        end
    end

    assign w_grant = bus.c3 && w_win_vld;
    assign w_exit  = r_tags[RD_LAT-1];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            // The tag pipeline is reset too: a transaction cut off by reset
            // must never produce a data strobe afterwards.
            r_vcnt           <= 4'd0;
            r_mem_req        <= 1'b0;
            r_mem_addr       <= '0;
            r_video_pre_next <= 1'b0;
            r_video_next     <= 1'b0;
            r_video_strobe   <= 1'b0;
            r_tm_next        <= 1'b0;
            r_ts_pre_next    <= 1'b0;
            r_ts_next        <= 1'b0;
            r_dram_rdata     <= '0;
            r_cmd            <= '0;
            r_tags           <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values, so the shift chain moves exactly one stage.
            r_mem_req        <= w_grant;
            r_video_pre_next <= w_grant && (w_win_own == OWN_VID);
            r_ts_pre_next    <= w_grant && (w_win_own == OWN_TS);
            r_video_next     <= r_video_pre_next;
            if (w_grant) begin
                r_mem_addr <= w_win_addr;
            end

            // A video win implies vcnt != 0, so a go pulse in the same cycle
            // is discarded by the else branch naturally.
            if (w_grant && (w_win_own == OWN_VID)) begin
                r_vcnt <= r_vcnt - 4'd1;
            end else if (bus.video_go && (r_vcnt == 4'd0)) begin
                r_vcnt <= {1'b0, bus.video_bw[2:0]} + 4'd1;
            end

            r_cmd.vld <= w_grant;
            r_cmd.wr  <= w_win_wr;
            r_cmd.own <= w_win_own;
            r_tags[0] <= r_cmd;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tags[i] <= r_tags[i-1];
            end

            if (w_exit.vld && !w_exit.wr) begin
                r_dram_rdata <= bus.mem_rdata;
            end
            r_video_strobe <= w_exit.vld && (w_exit.own == OWN_VID);
            r_tm_next      <= w_exit.vld && (w_exit.own == OWN_TM);
            r_ts_next      <= w_exit.vld && (w_exit.own == OWN_TS);
        end
    end

    assign bus.mem_req        = r_mem_req;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.video_pre_next = r_video_pre_next;
    assign bus.video_next     = r_video_next;
    assign bus.video_strobe   = r_video_strobe;
    assign bus.tm_next        = r_tm_next;
    assign bus.ts_pre_next    = r_ts_pre_next;
    assign bus.ts_next        = r_ts_next;
    assign bus.dram_rdata     = r_dram_rdata;

`ifdef VIDEO_DRAM_ARB_CPU_EN
    logic        r_mem_rnw;
    logic [15:0] r_mem_wdata;
    logic        r_cpu_ack;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_mem_rnw   <= 1'b1;
            r_mem_wdata <= '0;
            r_cpu_ack   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_mem_rnw <= ~w_win_wr;
            end
            if (w_grant && (w_win_own == OWN_CPU)) begin
                r_mem_wdata <= bus.cpu_wdata;
            end
            // Writes retire through the same pipeline, so the ack timing
            // does not depend on direction.
            r_cpu_ack <= w_exit.vld && (w_exit.own == OWN_CPU);
        end
    end

    assign bus.mem_rnw   = r_mem_rnw;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_ack   = r_cpu_ack;

    logic w_unused;
    assign w_unused = &{1'b0, bus.video_bw[4:3]};
`else
    assign bus.mem_rnw   = 1'b1;
    assign bus.mem_wdata = '0;
    assign bus.cpu_ack   = 1'b0;

    logic w_unused;
    assign w_unused = &{1'b0, bus.video_bw[4:3], bus.cpu_req, bus.cpu_rnw,
                        bus.cpu_addr, bus.cpu_wdata};
`endif

endmodule

// File: tb/tb_video_dram_arb.sv
// ---------------------------------------------------------------------------
// tb_video_dram_arb
//
// Directed bench for video_dram_arb. The main instance uses RD_LAT = 2 and a
// DRAM model that drives valid read data only in the cycle RD_LAT after the
// command. Two extra instances (RD_LAT = 1 and 3) share the slot strobe and
// tile-map request to measure strobe latency. Works with and without
// VIDEO_DRAM_ARB_CPU_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_video_dram_arb;

    localparam logic [3:0] K_VID  = 4'b1000;
    localparam logic [3:0] K_TM   = 4'b0100;
    localparam logic [3:0] K_TS   = 4'b0010;
    localparam logic [3:0] K_CPU  = 4'b0001;
    localparam logic [3:0] K_IDLE = 4'b0000;

    logic        clk   = 1'b0;
    logic        res_n = 1'b1;
    int unsigned cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    video_dram_arb_if bus ();
    video_dram_arb_if if_l1 ();
    video_dram_arb_if if_l3 ();

    video_dram_arb #(.RD_LAT(2)) dut    (.clk(clk), .res_n(res_n), .bus(bus.slave));
    video_dram_arb #(.RD_LAT(1)) dut_l1 (.clk(clk), .res_n(res_n), .bus(if_l1.slave));
    video_dram_arb #(.RD_LAT(3)) dut_l3 (.clk(clk), .res_n(res_n), .bus(if_l3.slave));

    always #5 clk = ~clk;

    // Slot strobe: c3 is high in every cycle whose count is 3 mod 4, so
    // grants appear in cycles that are 0 mod 4.
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.c3 = (cyc[1:0] == 2'd3);

    function automatic logic [15:0] mdat(input logic [20:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // Main DRAM model: one writable location, other addresses return mdat().
    logic        wr_vld = 1'b0;
    logic [20:0] wr_a   = '0;
    logic [15:0] wr_d   = '0;
    logic [1:0]  pv     = '0;
    logic [15:0] pd0    = '0;
    logic [15:0] pd1    = '0;

    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_rnw) begin
            wr_vld <= 1'b1;
            wr_a   <= bus.mem_addr;
            wr_d   <= bus.mem_wdata;
        end
        pv  <= {pv[0], bus.mem_req && bus.mem_rnw};
        pd0 <= (wr_vld && wr_a == bus.mem_addr) ? wr_d : mdat(bus.mem_addr);
        pd1 <= pd0;
    end
    assign bus.mem_rdata = pv[1] ? pd1 : 16'hDEAD;

    // Latency instances: tile-map traffic only, read data held after command.
    logic [15:0] h1 = '0;
    logic [15:0] h3 = '0;
    always @(posedge clk) begin
        if (if_l1.mem_req) h1 <= mdat(if_l1.mem_addr);
        if (if_l3.mem_req) h3 <= mdat(if_l3.mem_addr);
    end

    assign if_l1.c3 = bus.c3;        assign if_l3.c3 = bus.c3;
    assign if_l1.tm_req = bus.tm_req;  assign if_l3.tm_req = bus.tm_req;
    assign if_l1.tm_addr = bus.tm_addr; assign if_l3.tm_addr = bus.tm_addr;
    assign if_l1.mem_rdata = h1;     assign if_l3.mem_rdata = h3;
    assign if_l1.video_go = 1'b0;    assign if_l3.video_go = 1'b0;
    assign if_l1.video_addr = '0;    assign if_l3.video_addr = '0;
    assign if_l1.video_bw = '0;      assign if_l3.video_bw = '0;
    assign if_l1.ts_req = 1'b0;      assign if_l3.ts_req = 1'b0;
    assign if_l1.ts_addr = '0;       assign if_l3.ts_addr = '0;
    assign if_l1.cpu_req = 1'b0;     assign if_l3.cpu_req = 1'b0;
    assign if_l1.cpu_rnw = 1'b1;     assign if_l3.cpu_rnw = 1'b1;
    assign if_l1.cpu_addr = '0;      assign if_l3.cpu_addr = '0;
    assign if_l1.cpu_wdata = '0;     assign if_l3.cpu_wdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] all_strb();
        return {bus.video_pre_next, bus.video_next, bus.video_strobe, bus.tm_next,
                bus.ts_pre_next, bus.ts_next, bus.cpu_ack};
    endfunction

    function automatic logic [3:0] data_strb();
        return {bus.video_strobe, bus.tm_next, bus.ts_next, bus.cpu_ack};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic goto_grant();
        do step(); while (cyc[1:0] != 2'd0);
    endtask

    // One slot: grant cycle G, then G+1..G+3. Returns at the G+3 negedge,
    // before the next c3 edge, so request changes made by the caller apply
    // to the following slot.
    task automatic slot(input string tag, input logic [3:0] kind, input logic [20:0] addr,
                        input logic [15:0] data, input logic wr, input bit drop, input bit go);
        goto_grant();
        bus.video_go = 1'b0;
        check({tag, " mem_req"}, bus.mem_req, kind != K_IDLE);
        if (kind != K_IDLE) begin
            check({tag, " mem_addr"}, bus.mem_addr, addr);
            check({tag, " mem_rnw"}, bus.mem_rnw, !wr);
        end
        check({tag, " grant"}, {bus.video_pre_next, bus.ts_pre_next},
              {kind == K_VID, kind == K_TS});
        step();
        if (go) bus.video_go = 1'b1;
        check({tag, " video_next"}, {bus.video_next, bus.mem_req}, {kind == K_VID, 1'b0});
        if (kind == K_VID) bus.video_addr = bus.video_addr + 21'd1;
        step();
        bus.video_go = 1'b0;
        check({tag, " early strobe"}, data_strb(), K_IDLE);
        step();
        check({tag, " strobe"}, data_strb(), kind);
        if (kind != K_IDLE) check({tag, " dram_rdata"}, bus.dram_rdata, data);
        if (drop) begin
            case (kind)
                K_TM:    bus.tm_req  = 1'b0;
                K_TS:    bus.ts_req  = 1'b0;
                K_CPU:   bus.cpu_req = 1'b0;
                default: ;
            endcase
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nz;
        int lm, lat1, lat3;
        logic [15:0] dm, d1, d3;

        bus.video_go = 1'b0; bus.video_addr = '0; bus.video_bw = '0;
        bus.tm_req = 1'b0;   bus.tm_addr = '0;
        bus.ts_req = 1'b0;   bus.ts_addr = '0;
        bus.cpu_req = 1'b0;  bus.cpu_rnw = 1'b1; bus.cpu_addr = '0; bus.cpu_wdata = '0;

        // ---- reset values ------------------------------------------------
        #1 res_n = 1'b0;
        #2;
        check("rst mem_req", bus.mem_req, 1'b0);
        check("rst mem_rnw", bus.mem_rnw, 1'b1);
        check("rst mem_addr", bus.mem_addr, 21'h0);
        check("rst mem_wdata", bus.mem_wdata, 16'h0);
        check("rst dram_rdata", bus.dram_rdata, 16'h0);
        check("rst strobes", all_strb(), 7'h0);
        repeat (3) step();
        res_n = 1'b1;
        nz = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (all_strb() != 7'h0 || bus.mem_req) nz++;
        end
        check("idle after reset", nz, 0);

        // ---- 4-word video burst ------------------------------------------
        bus.video_bw   = 5'b00011;
        bus.video_addr = 21'h100;
        goto_grant();
        bus.video_go = 1'b1;
        step();
        bus.video_go = 1'b0;
        for (int i = 0; i < 4; i++)
            slot("burst", K_VID, 21'h100 + 21'(i), mdat(21'h100 + 21'(i)), 1'b0, 1'b0, 1'b0);
        slot("burst end", K_IDLE, '0, '0, 1'b0, 1'b0, 1'b0);

        // ---- priority, video burst starting mid-sequence ------------------
        bus.tm_req = 1'b1;  bus.tm_addr = 21'h200;
        bus.ts_req = 1'b1;  bus.ts_addr = 21'h300;
        bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 21'h500;
        bus.video_bw = 5'b00001; bus.video_addr = 21'h400;
        slot("pri tm", K_TM, 21'h200, mdat(21'h200), 1'b0, 1'b1, 1'b1);
        slot("pri vid0", K_VID, 21'h400, mdat(21'h400), 1'b0, 1'b0, 1'b0);
        slot("pri vid1", K_VID, 21'h401, mdat(21'h401), 1'b0, 1'b0, 1'b0);
        slot("pri ts", K_TS, 21'h300, mdat(21'h300), 1'b0, 1'b1, 1'b0);
`ifdef VIDEO_DRAM_ARB_CPU_EN
        slot("pri cpu", K_CPU, 21'h500, mdat(21'h500), 1'b0, 1'b1, 1'b0);
`else
        slot("pri cpu ignored", K_IDLE, '0, '0, 1'b0, 1'b0, 1'b0);
        bus.cpu_req = 1'b0;
`endif
        slot("pri end", K_IDLE, '0, '0, 1'b0, 1'b0, 1'b0);

        // ---- go on c3 (late load), then discarded second go --------------
        bus.tm_req = 1'b1; bus.tm_addr = 21'h210;
        bus.video_bw = 5'b00011; bus.video_addr = 21'h600;
        bus.video_go = 1'b1;                 // coincides with c3
        slot("go@c3 tm", K_TM, 21'h210, mdat(21'h210), 1'b0, 1'b0, 1'b0);
        bus.tm_addr = 21'h211;
        slot("disc vid0", K_VID, 21'h600, mdat(21'h600), 1'b0, 1'b0, 1'b0);
        bus.video_bw = 5'b00111;
        slot("disc vid1", K_VID, 21'h601, mdat(21'h601), 1'b0, 1'b0, 1'b1);
        slot("disc vid2", K_VID, 21'h602, mdat(21'h602), 1'b0, 1'b0, 1'b0);
        slot("disc vid3", K_VID, 21'h603, mdat(21'h603), 1'b0, 1'b0, 1'b0);
        slot("disc tm", K_TM, 21'h211, mdat(21'h211), 1'b0, 1'b1, 1'b0);
        slot("disc end", K_IDLE, '0, '0, 1'b0, 1'b0, 1'b0);

        // ---- CPU write / read-back ----------------------------------------
        bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b0;
        bus.cpu_addr = 21'h1FFFFF; bus.cpu_wdata = 16'hBEEF;
`ifdef VIDEO_DRAM_ARB_CPU_EN
        slot("cpu wr", K_CPU, 21'h1FFFFF, mdat(21'h211), 1'b1, 1'b0, 1'b0);
        check("cpu wr mem_wdata", bus.mem_wdata, 16'hBEEF);
        bus.cpu_rnw = 1'b1;
        slot("cpu rd", K_CPU, 21'h1FFFFF, 16'hBEEF, 1'b0, 1'b1, 1'b0);
`else
        slot("cpu off", K_IDLE, '0, '0, 1'b0, 1'b0, 1'b0);
        check("cpu off mem_rnw", bus.mem_rnw, 1'b1);
        check("cpu off mem_wdata", bus.mem_wdata, 16'h0);
        bus.cpu_req = 1'b0;
`endif

        // ---- RD_LAT sweep, request dropped before data -------------------
        bus.tm_req = 1'b1; bus.tm_addr = 21'h220;
        goto_grant();
        lm = -1; lat1 = -1; lat3 = -1; dm = '0; d1 = '0; d3 = '0;
        for (int k = 0; k < 6; k++) begin
            if (bus.tm_next)   begin lm   = k; dm = bus.dram_rdata;   end
            if (if_l1.tm_next) begin lat1 = k; d1 = if_l1.dram_rdata; end
            if (if_l3.tm_next) begin lat3 = k; d3 = if_l3.dram_rdata; end
            if (k == 1) bus.tm_req = 1'b0;
            if (k < 5) step();
        end
        check("lat2 strobe", lm, 3);
        check("lat1 strobe", lat1, 2);
        check("lat3 strobe", lat3, 4);
        check("lat2 data", dm, mdat(21'h220));
        check("lat1 data", d1, mdat(21'h220));
        check("lat3 data", d3, mdat(21'h220));

        // ---- reset one clk after a grant ---------------------------------
        bus.tm_req = 1'b1; bus.tm_addr = 21'h230;
        goto_grant();
        check("mid rst grant", {bus.mem_req, bus.mem_addr}, {1'b1, 21'h230});
        step();
        #2 res_n = 1'b0;
        #1;
        check("mid rst outputs", {bus.mem_req, bus.mem_rnw, bus.mem_addr, all_strb()},
              {1'b0, 1'b1, 21'h0, 7'h0});
        check("mid rst dram_rdata", bus.dram_rdata, 16'h0);
        bus.tm_req = 1'b0;
        step();
        res_n = 1'b1;
        nz = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (data_strb() != 4'h0 || if_l1.tm_next || if_l3.tm_next) nz++;
        end
        check("mid rst no strobe", nz, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
